op_dispatch: RTL and testbench
==============================

Name: op_dispatch

Overview:
Command-issue stage that sits directly upstream of the result-collection stage and the three arithmetic units (add/sub, multiply, sine/cosine).
- Accepts opcode+operand commands from the CPU into an 8-deep command FIFO.
- Decodes each command in order and pulses the matching unit's start strobe with the operands.
- Records every issued opcode in an 8-deep in-flight opcode queue. The queue head drives fifo_out to the result stage, which pops it with op_fifo_pop once the result is captured.

Parameters:
DEPTH, 8, entries in both the command FIFO and the in-flight opcode queue (power of 2)
DW, 32, operand width in bits
OPW, 3, opcode width in bits

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  reset: asynchronous, active-low
cpu_push  input  1  write cpu_opcode/cpu_op_a/cpu_op_b into the command FIFO this edge
cpu_opcode  input  3  000 NOP, 001 add, 010 sub, 011 mul, 100 sine, 101 cosine, 110/111 illegal
cpu_op_a  input  32  operand A (sole operand for sine/cosine)
cpu_op_b  input  32  operand B (ignored for sine/cosine)
op_fifo_pop  input  1  result stage retires the in-flight queue head
add_busy, mul_busy, sine_busy  input  1 each  unit cannot accept a new start
cmd_full  output  1  command FIFO holds DEPTH entries
cmd_empty  output  1  command FIFO holds 0 entries
cmd_err  output  1  one-cycle pulse: push dropped (full) or illegal/NOP opcode discarded
op_a, op_b  output  32 each  registered operands for the unit being started
add_start, mul_start, sine_start  output  1 each  one-cycle start strobes
sub_sel  output  1  1 = subtract (valid with add_start)
cos_sel  output  1  1 = cosine (valid with sine_start)
fifo_out  output  3  opcode at the in-flight queue head; 000 when the queue is empty
inflight_full  output  1  in-flight queue holds DEPTH entries

Behaviour:
- Reset (async, n_rst=0): both FIFOs are cleared and all pointers and counts are 0. FSM goes to IDLE.
  - Outputs after reset: op_a=op_b=0, all starts/sub_sel/cos_sel/cmd_err=0, fifo_out=000, cmd_empty=1, cmd_full=0, inflight_full=0.
  - Reset mid-operation drops every pending command and in-flight record. Starts deassert immediately.
- Command FIFO:
  - Circular buffer with wrap-around pointers and a 4-bit count.
  - cpu_push while cmd_full: the write is dropped and cmd_err pulses the next cycle. This holds even if a pop occurs on the same edge.
  - A push and an FSM pop on the same edge (not full) leave the count unchanged.
- FSM states: IDLE, DECODE, ISSUE.
  - IDLE: if !cmd_empty, go to DECODE next edge.
  - DECODE: examine the head opcode.
    - NOP or illegal: pop it, pulse cmd_err next cycle, go to IDLE if the FIFO becomes empty, otherwise stay in DECODE.
    - Legal: check that the target unit's busy is 0 and inflight_full=0. If so, on the same edge:
      - load op_a/op_b/sub_sel/cos_sel;
      - pop the command FIFO;
      - push the opcode into the in-flight queue;
      - go to ISSUE.
    - Legal but target busy or queue full: stall in DECODE with no side effects.
  - ISSUE: exactly one of add_start (001/010), mul_start (011) or sine_start (100/101) is high for one cycle. Next edge goes to DECODE if !cmd_empty, else IDLE.
- Latency: a push at edge E0 into an empty, idle block produces a start strobe in the cycle after edge E2. Minimum issue spacing is 2 cycles per command.
- op_a/op_b/sub_sel/cos_sel hold their value until the next issue.
- In-flight queue:
  - fifo_out reflects the head combinationally from registered state. It is valid in the same cycle as the corresponding start.
  - op_fifo_pop when the queue is empty is ignored, and the count stays 0.
  - A push and a pop on the same edge leave the count unchanged. Push is never attempted while full.
  - Entries leave strictly in issue order.
- Multiple in-flight operations on different units are allowed. Ordering is enforced downstream by head-opcode matching.

Test Plan:
- Reset with pushes pending -> every output reads its reset value, including cmd_empty=1, fifo_out=000; a later op_fifo_pop leaves the count at 0.
- Push {001, A=0x3F800000, B=0x40000000} at E0 -> add_start=1 and sub_sel=0 in cycle after E2 with op_a/op_b equal to the pushed values; fifo_out=001 in that cycle; op_fifo_pop -> fifo_out=000.
- Push 9 commands {011,...} back-to-back with mul_busy=1 -> cmd_full=1 after 8; the 9th push gives a cmd_err pulse; no mul_start occurs while busy; releasing busy -> 8 mul_starts spaced 2 cycles apart, and inflight_full=1 after the 8th.
- Push 000 then 111 then 101 -> two cmd_err pulses and no starts for the first two; sine_start with cos_sel=1 for the third; fifo_out=101.
- Push 001, 011, 100 with no busy and op_fifo_pop asserted on the same edge as the 3rd queue push -> the queue count stays consistent; fifo_out sequence across the three pops is 001, 011, 100, then 000.
- Assert n_rst=0 mid-ISSUE (add_start high) -> add_start drops asynchronously; after release there are no starts and fifo_out=000.

Source files
------------

// File: rtl/op_dispatch.sv
// Command-issue stage: buffers CPU commands, decodes them in order, strobes
// the matching arithmetic unit and tracks issued opcodes until the result
// stage retires them.
module op_dispatch #(
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  parameter int OPW   = 3
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           cpu_push,
  input  logic [OPW-1:0] cpu_opcode,
  input  logic [DW-1:0]  cpu_op_a,
  input  logic [DW-1:0]  cpu_op_b,
  input  logic           op_fifo_pop,
  input  logic           add_busy,
  input  logic           mul_busy,
  input  logic           sine_busy,
  output logic           cmd_full,
  output logic           cmd_empty,
  output logic           cmd_err,
  output logic [DW-1:0]  op_a,
  output logic [DW-1:0]  op_b,
  output logic           add_start,
  output logic           mul_start,
  output logic           sine_start,
  output logic           sub_sel,
  output logic           cos_sel,
  output logic [OPW-1:0] fifo_out,
  output logic           inflight_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_ADD = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB = OPW'(2);
  localparam logic [OPW-1:0] OP_MUL = OPW'(3);
  localparam logic [OPW-1:0] OP_SIN = OPW'(4);
  localparam logic [OPW-1:0] OP_COS = OPW'(5);

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DECODE, ISSUE} state_t;

  // command FIFO
  cmd_t          cq_mem [DEPTH];
  logic [AW-1:0] cq_wr, cq_rd;
  logic [CW-1:0] cq_cnt;
  logic          cq_push, cq_pop;

  // in-flight opcode queue
  logic [OPW-1:0] iq_mem [DEPTH];
  logic [AW-1:0]  iq_wr, iq_rd;
  logic [CW-1:0]  iq_cnt;
  logic           iq_pop;

  state_t         state;
  cmd_t           head;
  logic           head_bad, tgt_busy, dec_ok, drop, issue;

  assign cmd_full      = (cq_cnt == CW'(DEPTH));
  assign cmd_empty     = (cq_cnt == '0);
  assign inflight_full = (iq_cnt == CW'(DEPTH));
  assign fifo_out      = (iq_cnt == '0) ? '0 : iq_mem[iq_rd];

  assign cq_push  = cpu_push && !cmd_full;
  assign head     = cq_mem[cq_rd];
  assign head_bad = (head.op == OP_NOP) || (head.op > OP_COS);
  assign dec_ok   = (state == DECODE) && !cmd_empty;
  assign drop     = dec_ok && head_bad;
  assign issue    = dec_ok && !head_bad && !tgt_busy && !inflight_full;
  assign cq_pop   = drop || issue;
  assign iq_pop   = op_fifo_pop && (iq_cnt != '0);

  // route the head opcode to the busy flag of the unit it targets
  always_comb begin
    tgt_busy = 1'b1;
    case (head.op)
      OP_ADD, OP_SUB: tgt_busy = add_busy;
      OP_MUL:         tgt_busy = mul_busy;
      OP_SIN, OP_COS: tgt_busy = sine_busy;
      default:        tgt_busy = 1'b1;
    endcase
  end

  // storage writes; contents are never visible while the count says empty
  always_ff @(posedge clk) begin
    if (cq_push) cq_mem[cq_wr] <= {cpu_opcode, cpu_op_a, cpu_op_b};
    if (issue)   iq_mem[iq_wr] <= head.op;
  end

  // pointers and counts for both queues; power-of-2 depth wraps for free
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cq_wr  <= '0;
      cq_rd  <= '0;
      cq_cnt <= '0;
      iq_wr  <= '0;
      iq_rd  <= '0;
      iq_cnt <= '0;
    end else begin
      if (cq_push) cq_wr <= cq_wr + 1'b1;
      if (cq_pop)  cq_rd <= cq_rd + 1'b1;
      cq_cnt <= cq_cnt + CW'(cq_push) - CW'(cq_pop);
      if (issue)   iq_wr <= iq_wr + 1'b1;
      if (iq_pop)  iq_rd <= iq_rd + 1'b1;
      iq_cnt <= iq_cnt + CW'(issue) - CW'(iq_pop);
    end
  end

  // decode/issue FSM with registered operands, selects, strobes and error pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      sub_sel    <= 1'b0;
      cos_sel    <= 1'b0;
      add_start  <= 1'b0;
      mul_start  <= 1'b0;
      sine_start <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      add_start  <= 1'b0;
      mul_start  <= 1'b0;
      sine_start <= 1'b0;
      cmd_err    <= (cpu_push && cmd_full) || drop;
      case (state)
        IDLE: if (!cmd_empty) state <= DECODE;
        DECODE: begin
          if (cmd_empty) begin
            state <= IDLE;
          end else if (drop) begin
            // leave only if this pop drains the FIFO
            if (cq_cnt == CW'(1) && !cq_push) state <= IDLE;
          end else if (issue) begin
            op_a       <= head.a;
            op_b       <= head.b;
            sub_sel    <= (head.op == OP_SUB);
            cos_sel    <= (head.op == OP_COS);
            add_start  <= (head.op == OP_ADD) || (head.op == OP_SUB);
            mul_start  <= (head.op == OP_MUL);
            sine_start <= (head.op == OP_SIN) || (head.op == OP_COS);
            state      <= ISSUE;
          end
        end
        ISSUE:   state <= cmd_empty ? IDLE : DECODE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_op_dispatch.sv
// Bench for op_dispatch: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_op_dispatch;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        cpu_push = 1'b0;
  logic [2:0]  cpu_opcode = 3'd0;
  logic [31:0] cpu_op_a = 32'd0, cpu_op_b = 32'd0;
  logic        op_fifo_pop = 1'b0;
  logic        add_busy = 1'b0, mul_busy = 1'b0, sine_busy = 1'b0;
  logic        cmd_full, cmd_empty, cmd_err;
  logic [31:0] op_a, op_b;
  logic        add_start, mul_start, sine_start, sub_sel, cos_sel;
  logic [2:0]  fifo_out;
  logic        inflight_full;

  op_dispatch #(.DEPTH(DEPTH), .DW(32), .OPW(3)) dut (
    .clk(clk), .n_rst(n_rst), .cpu_push(cpu_push), .cpu_opcode(cpu_opcode),
    .cpu_op_a(cpu_op_a), .cpu_op_b(cpu_op_b), .op_fifo_pop(op_fifo_pop),
    .add_busy(add_busy), .mul_busy(mul_busy), .sine_busy(sine_busy),
    .cmd_full(cmd_full), .cmd_empty(cmd_empty), .cmd_err(cmd_err),
    .op_a(op_a), .op_b(op_b), .add_start(add_start), .mul_start(mul_start),
    .sine_start(sine_start), .sub_sel(sub_sel), .cos_sel(cos_sel),
    .fifo_out(fifo_out), .inflight_full(inflight_full)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  cmd_t        m_cq[$];
  logic [2:0]  m_iq[$];
  int          m_phase = 0;            // 0 waiting, 1 examining head, 2 strobing
  logic [31:0] e_a = 0, e_b = 0;
  logic        e_sub = 0, e_cos = 0, e_add = 0, e_mul = 0, e_sin = 0, e_err = 0;

  initial forever begin
    bit   push_ok, iq_was_full, iq_push;
    int   cq_n, nxt;
    cmd_t h;
    logic busy;
    @(posedge clk or negedge n_rst);
    if (!n_rst) begin
      m_cq.delete(); m_iq.delete(); m_phase = 0;
      e_a = 0; e_b = 0; e_sub = 0; e_cos = 0;
      e_add = 0; e_mul = 0; e_sin = 0; e_err = 0;
    end else begin
      cq_n        = m_cq.size();
      iq_was_full = (m_iq.size() == DEPTH);
      push_ok     = cpu_push && (cq_n < DEPTH);
      e_err       = cpu_push && (cq_n == DEPTH);
      e_add = 0; e_mul = 0; e_sin = 0;
      iq_push = 0;
      h = '0;
      nxt = m_phase;
      if (m_phase == 0) begin
        if (cq_n > 0) nxt = 1;
      end else if (m_phase == 1) begin
        if (cq_n == 0) nxt = 0;
        else begin
          h = m_cq[0];
          if (h.op == 3'd0 || h.op > 3'd5) begin
            void'(m_cq.pop_front());
            e_err = 1;
            nxt = ((cq_n - 1 + int'(push_ok)) == 0) ? 0 : 1;
          end else begin
            busy = (h.op <= 3'd2) ? add_busy : (h.op == 3'd3) ? mul_busy : sine_busy;
            if (!busy && !iq_was_full) begin
              void'(m_cq.pop_front());
              e_a = h.a; e_b = h.b;
              e_sub = (h.op == 3'd2); e_cos = (h.op == 3'd5);
              e_add = (h.op <= 3'd2); e_mul = (h.op == 3'd3); e_sin = (h.op >= 3'd4);
              iq_push = 1;
              nxt = 2;
            end
          end
        end
      end else begin
        nxt = (cq_n > 0) ? 1 : 0;
      end
      m_phase = nxt;
      if (op_fifo_pop && m_iq.size() > 0) void'(m_iq.pop_front());
      if (iq_push) m_iq.push_back(h.op);
      if (push_ok) m_cq.push_back({cpu_opcode, cpu_op_a, cpu_op_b});
    end
  end

  // every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("cmd_full",      32'(cmd_full),      32'(m_cq.size() == DEPTH));
    chk("cmd_empty",     32'(cmd_empty),     32'(m_cq.size() == 0));
    chk("inflight_full", 32'(inflight_full), 32'(m_iq.size() == DEPTH));
    chk("fifo_out",      32'(fifo_out),      32'((m_iq.size() > 0) ? m_iq[0] : 3'd0));
    chk("cmd_err",       32'(cmd_err),       32'(e_err));
    chk("add_start",     32'(add_start),     32'(e_add));
    chk("mul_start",     32'(mul_start),     32'(e_mul));
    chk("sine_start",    32'(sine_start),    32'(e_sin));
    chk("sub_sel",       32'(sub_sel),       32'(e_sub));
    chk("cos_sel",       32'(cos_sel),       32'(e_cos));
    chk("op_a",          op_a,               e_a);
    chk("op_b",          op_b,               e_b);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    cpu_push = 1'b1; cpu_opcode = op; cpu_op_a = a; cpu_op_b = b;
    @(negedge clk);
    cpu_push = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n_st, t_prev, bad_gap, n_err, n_sin, n_other, w;
    logic [31:0] first_a, last_a, sin_a;
    logic [2:0]  sin_fifo;
    logic        sin_cos;

    // reset with pushes pending
    cpu_push = 1'b1; cpu_opcode = 3'b001; cpu_op_a = 32'hDEAD; cpu_op_b = 32'hBEEF;
    repeat (3) @(negedge clk);
    chk("rst_cmd_empty", 32'(cmd_empty), 32'd1);
    chk("rst_cmd_full",  32'(cmd_full),  32'd0);
    chk("rst_fifo_out",  32'(fifo_out),  32'd0);
    chk("rst_op_a",      op_a,           32'd0);
    chk("rst_add_start", 32'(add_start), 32'd0);
    cpu_push = 1'b0;
    #2 n_rst = 1'b1;
    @(negedge clk);
    op_fifo_pop = 1'b1;
    @(negedge clk);
    op_fifo_pop = 1'b0;
    chk("rst_pop_empty", 32'(fifo_out), 32'd0);

    // single add: strobe in the cycle after E2
    push_cmd(3'b001, 32'h3F800000, 32'h40000000);
    chk("add_lat_e0", 32'(add_start), 32'd0);
    @(negedge clk);
    chk("add_lat_e1", 32'(add_start), 32'd0);
    @(negedge clk);
    chk("add_start_e2", 32'(add_start), 32'd1);
    chk("add_sub_sel",  32'(sub_sel),   32'd0);
    chk("add_op_a",     op_a,           32'h3F800000);
    chk("add_op_b",     op_b,           32'h40000000);
    chk("add_fifo_out", 32'(fifo_out),  32'd1);
    op_fifo_pop = 1'b1;
    @(negedge clk);
    op_fifo_pop = 1'b0;
    chk("add_retired", 32'(fifo_out), 32'd0);

    // nine muls against a busy multiplier
    mul_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_cmd(3'b011, 32'(i * 16 + 1), 32'(i));
      if (i == 7) begin
        chk("mul_full_after8", 32'(cmd_full), 32'd1);
        chk("mul_no_err8",     32'(cmd_err),  32'd0);
      end
      if (i == 8) chk("mul_err_9th", 32'(cmd_err), 32'd1);
    end
    chk("mul_none_busy", 32'(mul_start), 32'd0);
    mul_busy = 1'b0;
    n_st = 0; t_prev = -1; bad_gap = 0; first_a = 0; last_a = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mul_start) begin
        if (t_prev >= 0 && c - t_prev != 2) bad_gap++;
        if (n_st == 0) first_a = op_a;
        last_a = op_a;
        t_prev = c;
        n_st++;
      end
    end
    chk("mul_starts",     32'(n_st),          32'd8);
    chk("mul_gap",        32'(bad_gap),       32'd0);
    chk("mul_first_a",    first_a,            32'h1);
    chk("mul_last_a",     last_a,             32'h71);
    chk("mul_infl_full",  32'(inflight_full), 32'd1);
    chk("mul_cmd_empty",  32'(cmd_empty),     32'd1);
    op_fifo_pop = 1'b1;
    repeat (8) @(negedge clk);
    op_fifo_pop = 1'b0;
    chk("mul_drained",    32'(fifo_out),      32'd0);
    chk("mul_infl_clear", 32'(inflight_full), 32'd0);

    // NOP, illegal, cosine
    push_cmd(3'b000, 32'h0, 32'h0);
    push_cmd(3'b111, 32'h0, 32'h0);
    push_cmd(3'b101, 32'h1234, 32'h5678);
    n_err = 0; n_sin = 0; n_other = 0; sin_cos = 0; sin_fifo = 0; sin_a = 0;
    for (int c = 0; c < 12; c++) begin
      if (cmd_err) n_err++;
      if (add_start || mul_start) n_other++;
      if (sine_start) begin n_sin++; sin_cos = cos_sel; sin_fifo = fifo_out; sin_a = op_a; end
      @(negedge clk);
    end
    chk("bad_err_pulses", 32'(n_err),    32'd2);
    chk("bad_no_other",   32'(n_other),  32'd0);
    chk("cos_starts",     32'(n_sin),    32'd1);
    chk("cos_sel",        32'(sin_cos),  32'd1);
    chk("cos_fifo_out",   32'(sin_fifo), 32'd5);
    chk("cos_op_a",       sin_a,         32'h1234);
    op_fifo_pop = 1'b1;
    @(negedge clk);
    op_fifo_pop = 1'b0;

    // three units, pop overlapping the third queue push
    push_cmd(3'b001, 32'd1, 32'd2);
    push_cmd(3'b011, 32'd3, 32'd4);
    push_cmd(3'b100, 32'd5, 32'd6);
    w = 0;
    while (!mul_start && w < 20) begin @(negedge clk); w++; end
    chk("mix_mul_seen", 32'(mul_start), 32'd1);
    @(negedge clk);
    chk("mix_head1", 32'(fifo_out), 32'd1);
    op_fifo_pop = 1'b1;
    @(negedge clk);
    chk("mix_sine_start", 32'(sine_start), 32'd1);
    chk("mix_head2", 32'(fifo_out), 32'd3);
    @(negedge clk);
    chk("mix_head3", 32'(fifo_out), 32'd4);
    @(negedge clk);
    op_fifo_pop = 1'b0;
    chk("mix_head_empty", 32'(fifo_out), 32'd0);

    // reset while add_start is high
    push_cmd(3'b001, 32'hAA, 32'hBB);
    w = 0;
    while (!add_start && w < 10) begin @(negedge clk); w++; end
    chk("rst_mid_start_hi", 32'(add_start), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("rst_mid_start_lo", 32'(add_start), 32'd0);
    chk("rst_mid_fifo_out", 32'(fifo_out),  32'd0);
    #4 n_rst = 1'b1;
    n_st = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (add_start || mul_start || sine_start) n_st++;
    end
    chk("rst_mid_no_starts", 32'(n_st),     32'd0);
    chk("rst_mid_fifo_idle", 32'(fifo_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
